// File: rtl/axi_lite_master_pkg.sv
// Shared types for the AXI4-Lite master: response codes and FSM state encoding.
package axi_lite_master_pkg;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_EXOKAY = 2'b01,
    AXIL_SLVERR = 2'b10,
    AXIL_DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } axil_mst_state_t;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle (five channels, no clock) with master and slave views.
interface axi_lite_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Optional per-transaction timeout is enabled by defining AXIL_MST_TIMEOUT_EN.
//
// Handshake rule for every channel (cmd, rsp, AW, W, B, AR, R): a transfer happens on the rising
// edge where valid and ready are both high; once valid is raised its payload stays stable and
// valid stays high until that transfer (the timeout abort is the only deliberate exception).
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic                        busy,
  output axil_mst_state_t             dbg_state,
  axi_lite_master_if.master           m_axi
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("axi_lite_master: TIMEOUT_CYCLES must be >= 2");
  end

  axil_mst_state_t             state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                        write_q;
  logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                        aw_done, w_done;

  // A channel counts as done once its valid has dropped or is being accepted this cycle.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign dbg_state     = state_q;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_timeout_q;
  logic             txn_active, txn_done, tmo_fire;

  assign txn_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
  // A slave response arriving on the last counted cycle still wins over the abort.
  assign txn_done   = ((state_q == ST_WR_RESP) && m_axi.bvalid) ||
                      ((state_q == ST_RD_DATA) && m_axi.rvalid);
  assign tmo_fire   = txn_active && !txn_done && (tmo_cnt_q == TMO_LAST);
  assign rsp_timeout = rsp_timeout_q;

  // Wait counter: restarts on command accept, runs while a transaction is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && cmd_valid) begin
      tmo_cnt_q <= '0;
    end else if (txn_active) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transaction FSM with registered AXI, command and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_axi.bresp;
            state_q   <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= m_axi.rdata;
            rsp_resp  <= m_axi.rresp;
            state_q   <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef AXIL_MST_TIMEOUT_EN
      if ((state_q == ST_IDLE) && cmd_valid) rsp_timeout_q <= 1'b0;
      // Abort: release every AXI valid/ready so a hung slave cannot keep the bus locked.
      if (tmo_fire) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_write     <= write_q;
        rsp_rdata     <= '0;
        rsp_resp      <= AXIL_SLVERR;
        rsp_timeout_q <= 1'b1;
        state_q       <= ST_RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable-delay AXI4-Lite slave and an expected-response queue.
// The timeout step runs only when AXIL_MST_TIMEOUT_EN is defined.
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int RW = 1 + 1 + 2 + DW;  // {write, timeout, resp, rdata}

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  axil_mst_state_t dbg_state;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axi_lite_master #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy), .dbg_state(dbg_state), .m_axi(axi.master)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:1023];

  // Slave delay and response configuration
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_never = 1'b0, r_never = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Slave state
  logic [DW-1:0] slv_mem [0:1023];
  bit aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  bit ar_overlap_seen = 1'b0;
  logic [AW-1:0] aw_addr_s, ar_addr_s;
  logic [DW-1:0] w_data_s;
  logic [SW-1:0] w_strb_s;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  // Slave: record handshakes at the active edge
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 1'b0;
      w_got  = 1'b0;
      ar_got = 1'b0;
    end else begin
      if (axi.arvalid && (axi.awvalid || axi.wvalid)) ar_overlap_seen = 1'b1;
      if (axi.awvalid && axi.awready) begin aw_got = 1'b1; aw_addr_s = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin w_got = 1'b1; w_data_s = axi.wdata; w_strb_s = axi.wstrb; end
      if (axi.bvalid && axi.bready) begin
        if (bresp_cfg == 2'b00)
          for (int b = 0; b < SW; b++)
            if (w_strb_s[b]) slv_mem[aw_addr_s[11:2]][8*b +: 8] = w_data_s[8*b +: 8];
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (axi.arvalid && axi.arready) begin ar_got = 1'b1; ar_addr_s = axi.araddr; end
      if (axi.rvalid && axi.rready) ar_got = 1'b0;
    end
  end

  // Slave: drive ready/valid away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin axi.awready = 1'b0; aw_cnt = 0; end
      if (axi.wvalid) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
      else begin axi.wready = 1'b0; w_cnt = 0; end
      if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin axi.arready = 1'b0; ar_cnt = 0; end
      if (aw_got && w_got && !b_never) begin
        axi.bvalid = (b_cnt >= b_dly); axi.bresp = bresp_cfg; b_cnt++;
      end else begin
        axi.bvalid = 1'b0; axi.bresp = 2'b00; b_cnt = 0;
      end
      if (ar_got && !r_never) begin
        axi.rvalid = (r_cnt >= r_dly); axi.rresp = rresp_cfg;
        axi.rdata = slv_mem[ar_addr_s[11:2]]; r_cnt++;
      end else begin
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0; r_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present a command and optionally queue its expected response
  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input bit push);
    logic [DW-1:0] nv;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    if (push) begin
      if (wr) begin
        exp_q.push_back({1'b1, 1'b0, bresp_cfg, {DW{1'b0}}});
        if (bresp_cfg == 2'b00) begin
          nv = ref_mem[addr[11:2]];
          for (int b = 0; b < SW; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
          ref_mem[addr[11:2]] = nv;
        end
      end else begin
        exp_q.push_back({1'b0, 1'b0, rresp_cfg, ref_mem[addr[11:2]]});
      end
    end
  endtask

  // Driver: wait for acceptance, then check the request appears one cycle later
  task automatic wait_accept(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("cmd_accept", ok, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (cmd_write)
      check("wr_req_latency", {axi.awvalid, axi.wvalid, axi.arvalid, busy, cmd_ready}, 5'b11010);
    else
      check("rd_req_latency", {axi.awvalid, axi.wvalid, axi.arvalid, busy, cmd_ready}, 5'b00110);
  endtask

  // Scoreboard: compare the response at its handshake against the queue head
  task automatic wait_rsp(input int budget);
    bit seen = 1'b0;
    logic [RW-1:0] exp;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid && rsp_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("rsp_arrived", seen, 1);
    if (seen) begin
      check("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, exp);
      end
      @(posedge clk);
      @(negedge clk);
      check("idle_after_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
    end
  endtask

  initial begin
    bit hit;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {cmd_ready, busy, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                         axi.rready, rsp_valid, rsp_timeout}, 9'b100000000);
    check("reset_bus", {axi.awaddr, axi.araddr, axi.wdata, axi.wstrb}, 0);
    check("reset_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back, slave ready at once
    drive_cmd(1'b1, 12'h020, 32'h0000_0010, 4'hF, 1'b1);
    wait_accept(4);
    wait_rsp(10);
    drive_cmd(1'b0, 12'h020, '0, '0, 1'b1);
    wait_accept(4);
    wait_rsp(10);

    // Write with W accepted three cycles after AW, partial strobes
    w_dly = 3;
    drive_cmd(1'b1, 12'h024, 32'hDEAD_BEEF, 4'h3, 1'b1);
    wait_accept(4);
    @(negedge clk);
    check("aw_dropped_w_held", {axi.awvalid, axi.wvalid, dbg_state}, {1'b0, 1'b1, ST_WR_REQ});
    wait_rsp(20);
    w_dly = 0;

    // Delayed read channel
    ar_dly = 2; r_dly = 3;
    drive_cmd(1'b0, 12'h024, '0, '0, 1'b1);
    wait_accept(4);
    wait_rsp(20);
    ar_dly = 0; r_dly = 0;

    // Slave error codes pass through
    bresp_cfg = 2'b11;
    drive_cmd(1'b1, 12'h030, 32'hCAFE_0001, 4'hF, 1'b1);
    wait_accept(4);
    wait_rsp(10);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b10;
    drive_cmd(1'b0, 12'h020, '0, '0, 1'b1);
    wait_accept(4);
    wait_rsp(10);
    rresp_cfg = 2'b00;

    // Response back-pressure with a new command already waiting
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 12'h024, '0, '0, 1'b1);
    wait_accept(4);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("stall_rsp_seen", hit, 1);
    drive_cmd(1'b1, 12'h028, 32'h1234_5678, 4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {rsp_valid, cmd_ready, busy, rsp_write, rsp_resp, rsp_rdata},
            {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_BEEF});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_rsp(2);
    wait_accept(4);
    wait_rsp(10);

`ifdef AXIL_MST_TIMEOUT_EN
    // Slave never answers the write
    b_never = 1'b1;
    drive_cmd(1'b1, 12'h040, 32'h5555_AAAA, 4'hF, 1'b0);
    exp_q.push_back({1'b1, 1'b1, 2'b10, {DW{1'b0}}});
    wait_accept(4);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("timeout_rsp_seen", hit, 1);
    check("timeout_bus_released", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    wait_rsp(2);
`endif

    // Reset while waiting for read data
    r_never = 1'b1;
    drive_cmd(1'b0, 12'h020, '0, '0, 1'b0);
    wait_accept(4);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (axi.rready) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("rd_data_reached", {hit, dbg_state}, {1'b1, ST_RD_DATA});
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                               cmd_ready, busy, dbg_state}, {5'b00000, 1'b1, 1'b0, ST_IDLE});
    repeat (2) @(negedge clk);
    r_never = 1'b0;
    b_never = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_quiet", {rsp_valid, cmd_ready, busy}, 3'b010);
    end

    // Recovery read
    drive_cmd(1'b0, 12'h028, '0, '0, 1'b1);
    wait_accept(4);
    wait_rsp(10);

    check("queue_empty", exp_q.size(), 0);
    check("ar_never_with_aw", ar_overlap_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
